dtw_feeder: RTL and testbench

DTW_FEEDER -- requirements
Module: dtw_feeder

---
 rtl/dtw_pkg.sv | 17 +
 rtl/dtw_sample_buf.sv | 47 ++++
 rtl/dtw_feeder.sv | 174 +++++++++++++++++
 tb/tb_dtw_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_pkg.sv
// Shared types and defaults for the DTW feeder: FSM state encoding, default sizes and score sentinel.
package dtw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } feeder_state_t;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_SIZE       = 20;

    // Score reported when the engine never answers; replicated to the instance width.
    localparam logic [DEF_DATA_WIDTH-1:0] SCORE_SENTINEL = '1;

endpackage

// File: rtl/dtw_sample_buf.sv
// SIZE-entry sample register file with a bounds-checked write port and a wrapping read pointer.
// Read data follows the pointer combinationally, so an advance shows up on o_rd_data the next cycle.
module dtw_sample_buf
    import dtw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIZE       = DEF_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(SIZE)-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic                     i_rd_clr,
    input  logic                     i_rd_adv,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] L_LAST = AW'(SIZE - 1);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [AW-1:0]         r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (int'(i_wr_addr) < SIZE)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (i_rd_clr) begin
            r_rd_ptr <= '0;
        end else if (i_rd_adv) begin
            r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/dtw_feeder.sv
// Captures a camera window, then feeds reference/camera samples to a DTW engine and latches its score.
// Optional watchdog under DTW_FEEDER_TIMEOUT_EN forces FINISH with an all-ones score after TIMEOUT RUN cycles.
module dtw_feeder
    import dtw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIZE       = DEF_SIZE,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     cam_valid,
    input  logic [DATA_WIDTH-1:0]    cam_data,
    output logic                     cam_ready,
    input  logic                     ref_wr_en,
    input  logic [$clog2(SIZE)-1:0]  ref_wr_addr,
    input  logic [DATA_WIDTH-1:0]    ref_wr_data,
    output logic                     dtw_ready,
    input  logic                     dtw_ready_refer,
    input  logic                     dtw_ready_camera,
    output logic [DATA_WIDTH-1:0]    refer_out,
    output logic [DATA_WIDTH-1:0]    camera_out,
    input  logic                     dtw_done,
    input  logic [DATA_WIDTH-1:0]    dtw_score,
    output logic                     busy,
    output logic [DATA_WIDTH-1:0]    score_out,
    output logic                     score_valid
`ifdef DTW_FEEDER_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0]         L_LAST     = AW'(SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] L_SENTINEL = {DATA_WIDTH{SCORE_SENTINEL[0]}};

    feeder_state_t         r_state;
    feeder_state_t         w_state_nxt;
    logic [AW-1:0]         r_cam_wr_ptr;
    logic [DATA_WIDTH-1:0] r_score;
    logic                  w_start_acc;
    logic                  w_cam_acc;
    logic                  w_run_done;
    logic                  w_ref_adv;
    logic                  w_cam_adv;
    logic                  w_ref_wr;
    logic                  w_wd_hit;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_cam_acc   = (r_state == ST_FILL) && cam_valid;
    assign w_run_done  = (r_state == ST_RUN) && dtw_done;
    // A completing engine freezes the pointers, so done outranks any advance in the same cycle.
    assign w_ref_adv   = (r_state == ST_RUN) && dtw_ready_refer  && !dtw_done;
    assign w_cam_adv   = (r_state == ST_RUN) && dtw_ready_camera && !dtw_done;
    assign w_ref_wr    = ref_wr_en && ((r_state == ST_IDLE) || (r_state == ST_FILL));

`ifdef DTW_FEEDER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] L_WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_timeout_err;

    assign w_wd_hit    = (r_state == ST_RUN) && !dtw_done && (r_wd_cnt == L_WD_LAST);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if ((r_state == ST_FILL) && (w_state_nxt == ST_RUN)) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_start_acc) begin
                r_timeout_err <= 1'b0;
            end else if (w_wd_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cam_ready   = 1'b0;
        dtw_ready   = 1'b0;
        score_valid = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                cam_ready = 1'b1;
                if (cam_valid && (r_cam_wr_ptr == L_LAST)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                dtw_ready = 1'b1;
                if (dtw_done || w_wd_hit) w_state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
                score_valid = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cam_wr_ptr <= '0;
            r_score      <= '0;
        end else begin
            if (w_start_acc) begin
                r_cam_wr_ptr <= '0;
            end else if (w_cam_acc) begin
                r_cam_wr_ptr <= (r_cam_wr_ptr == L_LAST) ? '0 : r_cam_wr_ptr + 1'b1;
            end
            if (w_run_done) begin
                r_score <= dtw_score;
            end else if (w_wd_hit) begin
                r_score <= L_SENTINEL;
            end
        end
    end

    assign score_out = r_score;

    dtw_sample_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE)
    ) u_ref_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_ref_wr),
        .i_wr_addr (ref_wr_addr),
        .i_wr_data (ref_wr_data),
        .i_rd_clr  (w_start_acc),
        .i_rd_adv  (w_ref_adv),
        .o_rd_data (refer_out)
    );

    dtw_sample_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE       (SIZE)
    ) u_cam_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_cam_acc),
        .i_wr_addr (r_cam_wr_ptr),
        .i_wr_data (cam_data),
        .i_rd_clr  (w_start_acc),
        .i_rd_adv  (w_cam_adv),
        .o_rd_data (camera_out)
    );

endmodule

// File: tb/tb_dtw_feeder.sv
// Directed bench for dtw_feeder: vector table for RUN-phase advancing plus hand sequences for fill, done, reset and watchdog.
module tb_dtw_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cam_valid = 1'b0;
    logic [9:0] cam_data = '0;
    logic       cam_ready;
    logic       ref_wr_en = 1'b0;
    logic [4:0] ref_wr_addr = '0;
    logic [9:0] ref_wr_data = '0;
    logic       dtw_ready;
    logic       dtw_ready_refer = 1'b0;
    logic       dtw_ready_camera = 1'b0;
    logic [9:0] refer_out;
    logic [9:0] camera_out;
    logic       dtw_done = 1'b0;
    logic [9:0] dtw_score = '0;
    logic       busy;
    logic [9:0] score_out;
    logic       score_valid;
`ifdef DTW_FEEDER_TIMEOUT_EN
    logic       timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dtw_feeder #(
        .DATA_WIDTH (10),
        .SIZE       (20),
        .TIMEOUT    (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cam_valid        (cam_valid),
        .cam_data         (cam_data),
        .cam_ready        (cam_ready),
        .ref_wr_en        (ref_wr_en),
        .ref_wr_addr      (ref_wr_addr),
        .ref_wr_data      (ref_wr_data),
        .dtw_ready        (dtw_ready),
        .dtw_ready_refer  (dtw_ready_refer),
        .dtw_ready_camera (dtw_ready_camera),
        .refer_out        (refer_out),
        .camera_out       (camera_out),
        .dtw_done         (dtw_done),
        .dtw_score        (dtw_score),
        .busy             (busy),
        .score_out        (score_out),
        .score_valid      (score_valid)
`ifdef DTW_FEEDER_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    typedef struct {
        logic       refer_p;
        logic       cam_p;
        logic       start_p;
        logic [9:0] exp_ref;
        logic [9:0] exp_cam;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [9:0] base);
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                cam_valid = 1'b0;
                cam_data  = 10'h3EE;
                tick();
            end
            cam_valid = 1'b1;
            cam_data  = base + 10'(i);
            tick();
            if (i == 18) chk("cam_ready_before_last", 32'(cam_ready), 1);
        end
        cam_valid = 1'b0;
        chk("cam_ready_after_last", 32'(cam_ready), 0);
        chk("dtw_ready_run_entry", 32'(dtw_ready), 1);
        chk("refer_out_run_entry", 32'(refer_out), 0);
        chk("camera_out_run_entry", 32'(camera_out), 32'(base));
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 10'd1, 10'h100};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 10'd2, 10'h100};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 10'd3, 10'h100};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 10'd3, 10'h100};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 10'd3, 10'h101};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 10'd4, 10'h102};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 10'd5, 10'h103};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 10'd5, 10'h103};

        #3;
        chk("rst_cam_ready", 32'(cam_ready), 0);
        chk("rst_dtw_ready", 32'(dtw_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_score_valid", 32'(score_valid), 0);
        chk("rst_score_out", 32'(score_out), 0);
        chk("rst_refer_out", 32'(refer_out), 0);
        chk("rst_camera_out", 32'(camera_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            ref_wr_en   = 1'b1;
            ref_wr_addr = 5'(i);
            ref_wr_data = 10'(i);
            tick();
        end
        ref_wr_en = 1'b0;

        do_start();
        chk("fill_busy", 32'(busy), 1);
        chk("fill_cam_ready", 32'(cam_ready), 1);
        fill(10'h100);

        // write attempted while running must not reach the reference buffer
        ref_wr_en   = 1'b1;
        ref_wr_addr = 5'd0;
        ref_wr_data = 10'h3AA;
        tick();
        ref_wr_en = 1'b0;
        chk("ref_write_in_run", 32'(refer_out), 0);

        for (int v = 0; v < 8; v++) begin
            dtw_ready_refer  = vecs[v].refer_p;
            dtw_ready_camera = vecs[v].cam_p;
            start            = vecs[v].start_p;
            tick();
            dtw_ready_refer  = 1'b0;
            dtw_ready_camera = 1'b0;
            start            = 1'b0;
            chk($sformatf("vec%0d_refer", v), 32'(refer_out), 32'(vecs[v].exp_ref));
            chk($sformatf("vec%0d_camera", v), 32'(camera_out), 32'(vecs[v].exp_cam));
            chk($sformatf("vec%0d_dtw_ready", v), 32'(dtw_ready), 1);
        end

        dtw_ready_refer = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("refer_at_last", 32'(refer_out), 19);
        tick();
        dtw_ready_refer = 1'b0;
        chk("refer_wrap", 32'(refer_out), 0);

        dtw_ready_camera = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        dtw_ready_camera = 1'b0;
        chk("camera_wrap", 32'(camera_out), 32'h100);

        dtw_done         = 1'b1;
        dtw_score        = 10'h07B;
        dtw_ready_refer  = 1'b1;
        dtw_ready_camera = 1'b1;
        tick();
        dtw_done         = 1'b0;
        dtw_score        = '0;
        dtw_ready_refer  = 1'b0;
        dtw_ready_camera = 1'b0;
        chk("done_score_out", 32'(score_out), 32'h07B);
        chk("done_score_valid", 32'(score_valid), 1);
        chk("done_dtw_ready_low", 32'(dtw_ready), 0);
        chk("done_refer_frozen", 32'(refer_out), 0);
        chk("done_camera_frozen", 32'(camera_out), 32'h100);
        tick();
        chk("idle_score_valid", 32'(score_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_score_hold", 32'(score_out), 32'h07B);

        dtw_done  = 1'b1;
        dtw_score = 10'h222;
        tick();
        dtw_done  = 1'b0;
        dtw_score = '0;
        tick();
        chk("done_in_idle_score", 32'(score_out), 32'h07B);
        chk("done_in_idle_valid", 32'(score_valid), 0);
        chk("done_in_idle_busy", 32'(busy), 0);

        do_start();
        ref_wr_en   = 1'b1;
        ref_wr_addr = 5'd2;
        ref_wr_data = 10'h2BC;
        tick();
        ref_wr_en = 1'b0;
        fill(10'h200);
        dtw_ready_refer = 1'b1;
        tick();
        tick();
        dtw_ready_refer = 1'b0;
        chk("fill_phase_ref_write", 32'(refer_out), 32'h2BC);

        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(busy), 0);
        chk("midrun_rst_dtw_ready", 32'(dtw_ready), 0);
        chk("midrun_rst_refer", 32'(refer_out), 0);
        chk("midrun_rst_camera", 32'(camera_out), 0);
        chk("midrun_rst_score", 32'(score_out), 0);
        begin
            int sv_seen = 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (score_valid) sv_seen++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (score_valid) sv_seen++;
            end
            chk("midrun_rst_no_score_valid", 32'(sv_seen), 0);
        end
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_cam_ready", 32'(cam_ready), 0);

`ifdef DTW_FEEDER_TIMEOUT_EN
        chk("wd_rst_err", 32'(timeout_err), 0);
        do_start();
        fill(10'h300);
        for (int i = 0; i < 15; i++) tick();
        chk("wd_before_limit_busy", 32'(dtw_ready), 1);
        chk("wd_before_limit_err", 32'(timeout_err), 0);
        tick();
        chk("wd_score_sentinel", 32'(score_out), 32'h3FF);
        chk("wd_err_set", 32'(timeout_err), 1);
        chk("wd_score_valid", 32'(score_valid), 1);
        tick();
        chk("wd_err_sticky", 32'(timeout_err), 1);
        chk("wd_idle", 32'(busy), 0);
        do_start();
        chk("wd_err_cleared", 32'(timeout_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
